// File: rtl/reset_sequencer.sv
// reset_sequencer
//
// Takes the raw active-low board reset, synchronizes its deassertion to clk
// and then releases a bank of active-high domain resets one stage at a time,
// GAP cycles apart, so downstream blocks leave reset in a fixed order.
// A software soft reset (level request, acknowledged while in progress)
// re-asserts every stage, holds them for at least SW_HOLD cycles and then
// re-runs the staged release.
//
// Parameters
//   STAGES   number of downstream reset stages (1..8)
//   SYNC     synchronizer depth in flops (2..4)
//   GAP      cycles between consecutive stage releases (1..255)
//   SW_HOLD  minimum cycles all stages stay asserted on a soft reset (1..255)
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   asynchronous active-low reset
//   sw_req   in   soft-reset request level, synchronous to clk
//   sw_ack   out  high while a soft reset is in progress
//   rst_out  out  STAGES active-high stage resets, bit 0 released first
//   ready    out  high once every stage is released
//
// State | meaning
// ------+---------------------------------------------------------------
// SYNC  | reset deasserted, waiting for the synchronizer chain to fill
// SEQ   | releasing stages, one every GAP cycles, lowest index first
// RUN   | all stages released; the only state that accepts sw_req
// SOFT  | soft reset: all stages asserted, hold for SW_HOLD and req low

module reset_sequencer #(
  parameter int STAGES  = 3,
  parameter int SYNC    = 2,
  parameter int GAP     = 4,
  parameter int SW_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_req,
  output logic              sw_ack,
  output logic [STAGES-1:0] rst_out,
  output logic              ready
);

  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [7:0]       GAP_LAST  = 8'(GAP - 1);
  localparam logic [7:0]       HOLD_LAST = 8'(SW_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(STAGES - 1);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_SEQ  = 2'd1,
    ST_RUN  = 2'd2,
    ST_SOFT = 2'd3
  } state_t;

  state_t            state;
  logic [SYNC-1:0]   sync_q;
  logic [SYNC-1:0]   sync_d;
  logic [7:0]        gap_cnt;
  logic [7:0]        hold_cnt;
  logic [IDX_W-1:0]  idx;
  logic [STAGES-1:0] stage_mask;
  logic              sync_last_unused;

  // The FSM leaves SYNC on the same edge the last synchronizer flop fills,
  // so it looks at the chain's next value; the last flop's registered
  // output therefore has no consumer.
  assign sync_d           = {sync_q[SYNC-2:0], 1'b1};
  assign sync_last_unused = sync_q[SYNC-1];

  // One-hot select of the stage being released this step.
  assign stage_mask = STAGES'(1) << idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_SYNC;
      sync_q   <= '0;
      gap_cnt  <= '0;
      hold_cnt <= '0;
      idx      <= '0;
      rst_out  <= '1;
      ready    <= 1'b0;
      sw_ack   <= 1'b0;
    end else begin
      sync_q <= sync_d;

      unique case (state)
        ST_SYNC: begin
          if (sync_d[SYNC-1]) begin
            state   <= ST_SEQ;
            gap_cnt <= '0;
            idx     <= '0;
          end
        end

        ST_SEQ: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            rst_out <= rst_out & ~stage_mask;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              ready <= 1'b1;
              state <= ST_RUN;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        ST_RUN: begin
          if (sw_req) begin
            state    <= ST_SOFT;
            rst_out  <= '1;
            ready    <= 1'b0;
            sw_ack   <= 1'b1;
            hold_cnt <= '0;
          end
        end

        ST_SOFT: begin
          // Hold count saturates, so a request held past SW_HOLD exits on
          // the first edge that samples it low.
          if (hold_cnt == HOLD_LAST && !sw_req) begin
            state   <= ST_SEQ;
            sw_ack  <= 1'b0;
            gap_cnt <= '0;
            idx     <= '0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int STAGES  = 3;
  localparam int SYNC    = 2;
  localparam int GAP     = 4;
  localparam int SW_HOLD = 8;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       sw_req = 1'b0;
  logic       sw_ack;
  logic [2:0] rst_out;
  logic       ready;

  logic       c1_ack;
  logic [0:0] c1_rst;
  logic       c1_ready;
  logic       c8_ack;
  logic [7:0] c8_rst;
  logic       c8_ready;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int hold   = 0;
  logic req_lvl = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer #(.STAGES(STAGES), .SYNC(SYNC), .GAP(GAP), .SW_HOLD(SW_HOLD)) u_dut (
    .clk(clk), .reset(reset), .sw_req(sw_req),
    .sw_ack(sw_ack), .rst_out(rst_out), .ready(ready)
  );

  reset_sequencer #(.STAGES(1), .SYNC(3), .GAP(1), .SW_HOLD(1)) u_c1 (
    .clk(clk), .reset(reset), .sw_req(sw_req),
    .sw_ack(c1_ack), .rst_out(c1_rst), .ready(c1_ready)
  );

  reset_sequencer #(.STAGES(8), .SYNC(2), .GAP(255), .SW_HOLD(8)) u_c8 (
    .clk(clk), .reset(reset), .sw_req(sw_req),
    .sw_ack(c8_ack), .rst_out(c8_rst), .ready(c8_ready)
  );

  // ---------------- reference model (event-time based) ----------------
  int m_n;      // edges since reset deassertion
  int m_base;   // edge at which the current release sequence started
  int m_tsoft;  // edge at which the current soft reset was accepted
  bit m_soft;

  task automatic model_reset();
    m_n     = 0;
    m_base  = SYNC;
    m_soft  = 0;
    m_tsoft = 0;
  endtask

  function automatic logic [4:0] model_out();
    logic [2:0] r;
    logic       rdy;
    for (int i = 0; i < STAGES; i++)
      r[i] = m_soft || (m_n < m_base + (i + 1) * GAP);
    rdy = !m_soft && (m_n >= m_base + STAGES * GAP);
    return {r, rdy, m_soft};
  endfunction

  task automatic model_step(input logic r);
    bit was_run;
    was_run = !m_soft && (m_n >= m_base + STAGES * GAP);
    m_n++;
    if (was_run && r) begin
      m_soft  = 1;
      m_tsoft = m_n;
    end else if (m_soft && !r && (m_n >= m_tsoft + SW_HOLD)) begin
      m_soft = 0;
      m_base = m_n;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_pk();
    return {11'b0, rst_out, ready, sw_ack};
  endfunction

  function automatic logic [15:0] c1_pk();
    return {13'b0, c1_rst, c1_ready, c1_ack};
  endfunction

  function automatic logic [15:0] c8_pk();
    return {6'b0, c8_rst, c8_ready, c8_ack};
  endfunction

  // Drive sw_req away from the edge, take one rising edge, settle.
  task automatic tick(input logic r);
    sw_req = r;
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int         at;
    logic [2:0] rst;
    logic       rdy;
    logic       ack;
  } vec_t;

  vec_t vecs[25];
  logic req_sched[0:127];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1,  3'b111, 1'b0, 1'b0};
    vecs[1]  = '{5,  3'b111, 1'b0, 1'b0};
    vecs[2]  = '{6,  3'b110, 1'b0, 1'b0};
    vecs[3]  = '{7,  3'b110, 1'b0, 1'b0};
    vecs[4]  = '{8,  3'b110, 1'b0, 1'b0};
    vecs[5]  = '{9,  3'b110, 1'b0, 1'b0};
    vecs[6]  = '{10, 3'b100, 1'b0, 1'b0};
    vecs[7]  = '{13, 3'b100, 1'b0, 1'b0};
    vecs[8]  = '{14, 3'b000, 1'b1, 1'b0};
    vecs[9]  = '{20, 3'b111, 1'b0, 1'b1};
    vecs[10] = '{27, 3'b111, 1'b0, 1'b1};
    vecs[11] = '{28, 3'b111, 1'b0, 1'b0};
    vecs[12] = '{31, 3'b111, 1'b0, 1'b0};
    vecs[13] = '{32, 3'b110, 1'b0, 1'b0};
    vecs[14] = '{36, 3'b100, 1'b0, 1'b0};
    vecs[15] = '{39, 3'b100, 1'b0, 1'b0};
    vecs[16] = '{40, 3'b000, 1'b1, 1'b0};
    vecs[17] = '{50, 3'b111, 1'b0, 1'b1};
    vecs[18] = '{64, 3'b111, 1'b0, 1'b1};
    vecs[19] = '{65, 3'b111, 1'b0, 1'b0};
    vecs[20] = '{68, 3'b111, 1'b0, 1'b0};
    vecs[21] = '{69, 3'b110, 1'b0, 1'b0};
    vecs[22] = '{73, 3'b100, 1'b0, 1'b0};
    vecs[23] = '{76, 3'b100, 1'b0, 1'b0};
    vecs[24] = '{77, 3'b000, 1'b1, 1'b0};

    for (int i = 0; i < 128; i++) req_sched[i] = 1'b0;
    req_sched[7]  = 1'b1;                 // during SEQ: must be ignored
    req_sched[20] = 1'b1;                 // short request, low from edge 22
    req_sched[21] = 1'b1;
    for (int i = 50; i <= 64; i++) req_sched[i] = 1'b1;  // long request

    // ---- power-up ----
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_dut", dut_pk(), 16'b11100);
    check("hold_c1",  c1_pk(),  16'b100);
    check("hold_c8",  c8_pk(),  {6'b0, 8'hFF, 2'b00});
    @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;

    for (int k = 0; k < 25; k++) begin
      while (edge_n < vecs[k].at) tick(req_sched[edge_n + 1]);
      check($sformatf("vec@%0d", vecs[k].at), dut_pk(),
            {11'b0, vecs[k].rst, vecs[k].rdy, vecs[k].ack});
    end

    // ---- reset between edges 8 and 9, then identical restart ----
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
    while (edge_n < 8) tick(1'b0);
    check("seq_pre_rst", dut_pk(), 16'b11000);
    reset = 1'b0;
    #1;
    check("seq_async_rst", dut_pk(), 16'b11100);
    repeat (2) @(posedge clk);
    #1;
    check("seq_rst_hold", dut_pk(), 16'b11100);
    @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
    while (edge_n < 5)  tick(1'b0);
    check("rerun_e5", dut_pk(), 16'b11100);
    while (edge_n < 6)  tick(1'b0);
    check("rerun_e6", dut_pk(), 16'b11000);
    while (edge_n < 10) tick(1'b0);
    check("rerun_e10", dut_pk(), 16'b10000);
    while (edge_n < 13) tick(1'b0);
    check("rerun_e13", dut_pk(), 16'b10000);
    while (edge_n < 14) tick(1'b0);
    check("rerun_e14", dut_pk(), 16'b00010);

    // ---- reset in the middle of a soft reset ----
    while (edge_n < 19) tick(1'b0);
    tick(1'b1);
    check("soft_enter", dut_pk(), 16'b11101);
    tick(1'b1);
    reset = 1'b0;
    #1;
    check("soft_async_rst", dut_pk(), 16'b11100);

    // ---- randomized run against the model ----
    model_reset();
    hold    = 2;
    req_lvl = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (!reset) begin
        if (hold == 0) reset = 1'b1;
        else hold--;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check("rand_async_rst", dut_pk(), {11'b0, model_out()});
        hold = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 5) == 0) req_lvl = !req_lvl;
      sw_req = req_lvl;
      @(posedge clk);
      if (reset) model_step(sw_req);
      #1;
      check("rand", dut_pk(), {11'b0, model_out()});
    end

    // ---- parameter corners ----
    @(negedge clk);
    reset  = 1'b0;
    sw_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
    while (edge_n < 2048) begin
      tick(edge_n + 1 == 2045);
      case (edge_n)
        3:    check("c1_e3",    c1_pk(), 16'b100);
        4:    check("c1_e4",    c1_pk(), 16'b010);
        257:  check("c8_e257",  c8_pk(), {6'b0, 8'hFE, 2'b00});
        1787: check("c8_e1787", c8_pk(), {6'b0, 8'h80, 2'b00});
        2041: check("c8_e2041", c8_pk(), {6'b0, 8'h80, 2'b00});
        2042: check("c8_e2042", c8_pk(), {6'b0, 8'h00, 2'b10});
        2045: check("c1_soft",  c1_pk(), 16'b101);
        2046: check("c1_exit",  c1_pk(), 16'b100);
        2047: check("c1_rel",   c1_pk(), 16'b010);
        default: ;
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the board/chip reset, synchronizes its deassertion to `clk`, and releases a set of downstream active-high domain resets one stage at a time with a fixed gap between stages. It also accepts a software soft-reset request through a req/ack handshake, re-asserting all stages and re-running the release sequence. It sits between the reset source and the processor core sub-blocks (e.g. register file, datapath, memory interface) so they leave reset in a defined order.

## Interface
- `STAGES`, 3: number of downstream reset stages; legal 1..8.
- `SYNC`, 2: synchronizer depth in flops; legal 2..4.
- `GAP`, 4: cycles between consecutive stage releases; legal 1..255.
- `SW_HOLD`, 8: minimum cycles all stages stay asserted on a soft reset; legal 1..255.

- `clk`  in  1  single clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sw_req`  in  1  soft-reset request, level, synchronous to `clk`.
- `sw_ack`  out  1  high while soft reset is in progress.
- `rst_out`  out  STAGES  active-high stage resets; bit 0 is released first.
- `ready`  out  1  high when all stages are released.

## Operation
- States: SYNC, SEQ, RUN, SOFT.
- `reset` low, asynchronously and at any time: synchronizer cleared, state SYNC, `rst_out` = all ones, `ready` = 0, `sw_ack` = 0, counters = 0.
- SYNC: the SYNC-flop chain shifts in 1 each edge. When the last flop is 1, go to SEQ with gap counter = 0 and stage index = 0.
- SEQ: the gap counter increments each edge. When it reaches GAP-1, clear `rst_out[index]`, zero the counter, and increment the index. Releasing the last stage also sets `ready` and moves to RUN. Released bits stay 0; unreleased bits stay 1.
- RUN: `sw_req` is sampled only in RUN. When `sw_req` = 1 at an edge, go to SOFT on that edge: `rst_out` = all ones, `ready` = 0, `sw_ack` = 1, hold counter = 0.
- SOFT: the hold counter increments each edge and saturates at SW_HOLD-1. Exit to SEQ (counter and index = 0, `sw_ack` = 0) at the first edge where the hold count is SW_HOLD-1 and `sw_req` = 0. If `sw_req` is still high, stay in SOFT indefinitely.
- `sw_req` in SYNC or SEQ is ignored; no request is queued.
- All outputs are registered; no combinational path from input to output.

## Timing
- Edges are counted from edge 1, the first rising edge with `reset` high.
- The synchronizer is full at edge SYNC.
- `rst_out[i]` falls at edge SYNC + (i+1)·GAP.
- `ready` rises at edge SYNC + STAGES·GAP, the same edge `rst_out[STAGES-1]` falls.
- Soft reset, with request sampled at edge T:
  - `rst_out`, `ready` and `sw_ack` change at edge T, zero added latency.
  - If `sw_req` is low by edge T+SW_HOLD, exit is at T+SW_HOLD. Otherwise exit is at the first later edge that samples `sw_req` low.
  - With exit edge X: `sw_ack` falls at X, and `rst_out[i]` falls at X + (i+1)·GAP.
- `reset` low mid-SEQ or mid-SOFT: immediate asynchronous return to the reset values. The full sequence restarts after the next deassertion.
- `reset` deasserting within setup/hold of an edge: the result may be edge 1 or edge 2. The bench accepts either, with a one-cycle shift on everything after it.
- GAP = 1: consecutive stages release on consecutive edges.

## Test plan
Defaults (STAGES=3, SYNC=2, GAP=4, SW_HOLD=8) unless stated.

- Power-up: `reset` held low for 3 cycles, then high → `rst_out` = 111 during reset; 110 after edge 6; 100 after edge 10; 000 and `ready` = 1 after edge 14.
- Soft reset, short request: in RUN, `sw_req` high at edge T and low from T+2 → `rst_out` = 111 and `sw_ack` = 1 after T; `sw_ack` = 0 after T+8; `rst_out[0..2]` fall at T+12, T+16, T+20.
- Soft reset, long request: `sw_req` held high until just before edge T+15 → SOFT holds to T+15; `rst_out[0]` falls at T+19; `sw_ack` stays high through T+14.
- Reset mid-sequence: `reset` pulled low between edges 8 and 9 → `rst_out` = 111 and `ready` = 0 asynchronously. After re-deassertion, timing is identical to the power-up case.
- Request outside RUN: `sw_req` pulsed high at edge 7 (during SEQ) → ignored; `sw_ack` stays 0; `ready` rises at edge 14 unchanged.
- Parameter corners: STAGES=1, GAP=1, SYNC=3 → `rst_out[0]` and `ready` change at edge 4. STAGES=8, GAP=255 → last stage falls at edge 2+8·255.
